// File: rtl/hatch_ctrl_if.sv
// Control/status bundle between the incubation sequencer and its surroundings:
// button pulses and temperature in, display enable / stage / alarm / done out.
interface hatch_ctrl_if;
  logic       start_btn;
  logic       pause_btn;
  logic [6:0] temp_in;
  logic       st;
  logic [3:0] num;
  logic       temp;
  logic       done;

  modport master (
    output start_btn, pause_btn, temp_in,
    input  st, num, temp, done
  );

  modport slave (
    input  start_btn, pause_btn, temp_in,
    output st, num, temp, done
  );
endinterface

// File: rtl/hatch_ctrl.sv
// Incubation sequencer: advances a growth-stage index at a fixed in-band RUN rate,
// freezing while paused or while the incubator temperature is out of band.
module hatch_ctrl #(
  parameter int unsigned CLK_HZ     = 1000,
  parameter int unsigned STAGE_SEC  = 3,
  parameter int unsigned NUM_STAGES = 12,
  parameter int unsigned T_LOW      = 37,
  parameter int unsigned T_HIGH     = 39
) (
  input  logic         clk,
  input  logic         rst,
  hatch_ctrl_if.slave  bus
);

  localparam int unsigned TickW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SecW  = (STAGE_SEC > 1) ? $clog2(STAGE_SEC) : 1;

  localparam logic [TickW-1:0] TickMax   = TickW'(CLK_HZ - 1);
  localparam logic [SecW-1:0]  SecMax    = SecW'(STAGE_SEC - 1);
  localparam logic [3:0]       LastStage = 4'(NUM_STAGES - 1);
  localparam logic [6:0]       TLow      = 7'(T_LOW);
  localparam logic [6:0]       THigh     = 7'(T_HIGH);

  typedef enum logic [2:0] {StIdle, StRun, StHold, StPause, StDone} state_e;

  state_e           state_q;
  logic [TickW-1:0] tick_q;
  logic [SecW-1:0]  sec_q;
  logic [3:0]       num_q;
  logic             st_q;
  logic             temp_q;
  logic             done_q;

  logic       oob;
  logic [3:0] num_inc;

  assign oob     = (bus.temp_in < TLow) || (bus.temp_in > THigh);
  assign num_inc = num_q + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tick_q  <= '0;
      sec_q   <= '0;
      num_q   <= '0;
      st_q    <= 1'b0;
      temp_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      temp_q <= (state_q == StIdle) ? 1'b0 : oob;
      unique case (state_q)
        StIdle: begin
          if (bus.start_btn) begin
            state_q <= StRun;
            st_q    <= 1'b1;
            tick_q  <= '0;
            sec_q   <= '0;
            num_q   <= '0;
          end
        end
        StRun: begin
          if (bus.pause_btn) begin
            state_q <= StPause;
          end else if (oob) begin
            state_q <= StHold;
          end else if (tick_q == TickMax) begin
            tick_q <= '0;
            if (sec_q == SecMax) begin
              sec_q <= '0;
              num_q <= num_inc;
              // Reaching the final stage is terminal: no further counting.
              if (num_inc == LastStage) begin
                state_q <= StDone;
                done_q  <= 1'b1;
              end
            end else begin
              sec_q <= sec_q + 1'b1;
            end
          end else begin
            tick_q <= tick_q + 1'b1;
          end
        end
        StHold: begin
          if (bus.pause_btn) begin
            state_q <= StPause;
          end else if (!oob) begin
            state_q <= StRun;
          end
        end
        StPause: begin
          if (bus.pause_btn) begin
            state_q <= StRun;
          end
        end
        StDone: begin
          if (bus.start_btn) begin
            state_q <= StRun;
            done_q  <= 1'b0;
            tick_q  <= '0;
            sec_q   <= '0;
            num_q   <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.st   = st_q;
  assign bus.num  = num_q;
  assign bus.temp = temp_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_hatch_ctrl.sv
// Scoreboard bench for hatch_ctrl: a run-edge-count reference model pushes expected
// outputs per driven cycle; they are popped and compared one edge later.
module tb_hatch_ctrl;

  localparam int CLK_HZ     = 4;
  localparam int STAGE_SEC  = 2;
  localparam int NUM_STAGES = 12;
  localparam int PER_STAGE  = CLK_HZ * STAGE_SEC;

  localparam int MIdle  = 0;
  localparam int MRun   = 1;
  localparam int MHold  = 2;
  localparam int MPause = 3;
  localparam int MDone  = 4;

  typedef struct {
    string tag;
    int    st;
    int    num;
    int    temp;
    int    done;
  } exp_t;

  logic clk;
  logic rst;
  hatch_ctrl_if bus ();

  hatch_ctrl #(
    .CLK_HZ    (CLK_HZ),
    .STAGE_SEC (STAGE_SEC),
    .NUM_STAGES(NUM_STAGES),
    .T_LOW     (37),
    .T_HIGH    (39)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   m_mode = MIdle;
  int   m_runs = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: progress is the total number of counting RUN edges since start.
  task automatic model_step(input bit s, input bit p, input int t, input string tag);
    exp_t e;
    bit   oob;
    oob    = (t < 37) || (t > 39);
    e.tag  = tag;
    e.temp = (m_mode == MIdle) ? 0 : int'(oob);
    case (m_mode)
      MIdle:  if (s) begin m_mode = MRun; m_runs = 0; end
      MRun: begin
        if (p) m_mode = MPause;
        else if (oob) m_mode = MHold;
        else begin
          m_runs++;
          if (m_runs / PER_STAGE == NUM_STAGES - 1) m_mode = MDone;
        end
      end
      MHold:  if (p) m_mode = MPause; else if (!oob) m_mode = MRun;
      MPause: if (p) m_mode = MRun;
      MDone:  if (s) begin m_mode = MRun; m_runs = 0; end
      default: m_mode = MIdle;
    endcase
    e.st   = (m_mode == MIdle) ? 0 : 1;
    e.num  = (m_mode == MIdle) ? 0 : m_runs / PER_STAGE;
    e.done = (m_mode == MDone) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input bit s, input bit p, input int t, input string tag);
    exp_t e;
    @(negedge clk);
    bus.start_btn = s;
    bus.pause_btn = p;
    bus.temp_in   = 7'(t);
    model_step(s, p, t, tag);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, "_st"},   int'(bus.st),   e.st);
      chk({e.tag, "_num"},  int'(bus.num),  e.num);
      chk({e.tag, "_temp"}, int'(bus.temp), e.temp);
      chk({e.tag, "_done"}, int'(bus.done), e.done);
    end
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
  endtask

  task automatic run(input int n, input int t, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, t, tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_st"},   int'(bus.st),   0);
    chk({tag, "_num"},  int'(bus.num),  0);
    chk({tag, "_temp"}, int'(bus.temp), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    m_mode = MIdle;
    m_runs = 0;
    exp_q.delete();
  endtask

  initial begin
    rst           = 1'b1;
    bus.start_btn = 1'b0;
    bus.pause_btn = 1'b0;
    bus.temp_in   = 7'd20;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_st",   int'(bus.st),   0);
    chk("rst_num",  int'(bus.num),  0);
    chk("rst_temp", int'(bus.temp), 0);
    chk("rst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle: pause ignored, temp forced low even when out of band
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 20, "idle_pause");
      cycle(1'b0, 1'b0, 20, "idle");
    end

    // Nominal run through to DONE and beyond
    cycle(1'b1, 1'b0, 38, "nom_start");
    run(PER_STAGE * (NUM_STAGES - 1) + 6, 38, "nom_run");
    cycle(1'b0, 1'b1, 38, "done_pause");
    run(3, 38, "done_hold");

    // Restart from DONE, then a temperature excursion after 5 RUN edges
    cycle(1'b1, 1'b0, 38, "restart");
    run(5, 38, "hold_pre");
    run(20, 40, "hold_oob");
    run(6, 38, "hold_post");

    // Pause mid-stage for 10 edges
    run(2, 38, "pause_pre");
    cycle(1'b0, 1'b1, 38, "pause_on");
    run(10, 38, "paused");
    cycle(1'b1, 1'b0, 38, "pause_start_ign");
    cycle(1'b0, 1'b1, 38, "pause_off");
    run(9, 38, "pause_post");

    // Pause together with oob wins; resume while oob goes RUN then HOLD
    cycle(1'b0, 1'b1, 41, "pause_oob");
    run(3, 41, "pause_oob_hold");
    cycle(1'b0, 1'b1, 41, "resume_oob");
    run(2, 41, "resume_oob_hold");
    cycle(1'b0, 1'b1, 41, "hold_pause");
    cycle(1'b0, 1'b1, 38, "hold_pause_off");
    run(3, 38, "resume_run");

    // Temperature band boundaries
    run(2, 37, "bnd_37");
    run(2, 39, "bnd_39");
    run(2, 36, "bnd_36");
    run(2, 37, "bnd_back");
    run(2, 40, "bnd_40");
    run(2, 38, "bnd_back2");
    cycle(1'b1, 1'b0, 38, "run_start_ign");

    // Async reset mid-session at num=5
    do_reset("mid_rst0");
    cycle(1'b1, 1'b0, 38, "rst5_start");
    run(PER_STAGE * 5, 38, "rst5_run");
    chk("rst5_num_reached", int'(bus.num), 5);
    do_reset("mid_rst5");

    // Start and pause together in IDLE: start wins
    cycle(1'b1, 1'b1, 38, "both_idle");
    run(PER_STAGE + 1, 38, "both_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hatch_ctrl.md
# hatch_ctrl

Incubation sequencer for the egg-hatch board, sitting directly upstream of the dot-matrix display stage. Runs from the 1 kHz system clock and tracks a start/pause session. It freezes progress while the measured incubator temperature is out of band, and advances a growth-stage index 0..NUM_STAGES-1 at a fixed rate. It drives the display's `st` (display enable), `num` (stage index) and `temp` (temperature-alarm colouring) inputs.

## Interface
- CLK_HZ, 1000, clk cycles per second; prescaler terminal count is CLK_HZ-1.
- STAGE_SEC, 3, seconds of in-band RUN time per stage (>=1).
- NUM_STAGES, 12, number of stages; final stage index is NUM_STAGES-1 (<=16).
- T_LOW, 37, lowest in-band temperature, °C, inclusive.
- T_HIGH, 39, highest in-band temperature, °C, inclusive.
- clk  in  1  system clock, 1 kHz.
- rst  in  1  reset, asynchronous, active-high.
- start_btn  in  1  debounced one-cycle pulse: start or restart session.
- pause_btn  in  1  debounced one-cycle pulse: toggle pause.
- temp_in  in  7  incubator temperature, unsigned °C.
- st  out  1  session active; display enable.
- num  out  4  current stage index.
- temp  out  1  1 = temperature out of band (alarm).
- done  out  1  1 = final stage reached.

## Operation
- States: IDLE, RUN, HOLD, PAUSE, DONE. Reset to IDLE.
- Registers: tick_cnt (0..CLK_HZ-1), sec_cnt (0..STAGE_SEC-1), num, state, temp flag.
- `oob = (temp_in < T_LOW) || (temp_in > T_HIGH)`, unsigned compare.
- IDLE
  - Outputs: st=0, num=0, temp=0, done=0.
  - start_btn -> RUN and clears tick_cnt, sec_cnt and num.
  - pause_btn ignored.
- RUN
  - st=1.
  - Priority, highest first: pause_btn -> PAUSE; oob -> HOLD; otherwise count.
  - Counting: tick_cnt increments and wraps at CLK_HZ-1.
  - On wrap: sec_cnt increments; at STAGE_SEC-1 it wraps to 0 and num increments.
  - If the incremented num equals NUM_STAGES-1, go to DONE in the same edge.
- HOLD
  - st=1. tick_cnt, sec_cnt and num are frozen (retain value, no clear).
  - Priority: pause_btn -> PAUSE; !oob -> RUN.
- PAUSE
  - st=1. Counters are frozen.
  - pause_btn -> RUN. If oob, RUN then moves to HOLD on the next edge.
  - start_btn ignored.
- DONE
  - st=1, done=1, num=NUM_STAGES-1, counters stop.
  - start_btn -> RUN with num, sec_cnt and tick_cnt cleared.
  - pause_btn ignored.
- start_btn in RUN, HOLD or PAUSE is ignored; only rst aborts a session.
- temp output is registered as `oob` in every state except IDLE, where it is forced to 0.
- Simultaneous start_btn and pause_btn in IDLE or DONE: start wins.

## Timing
- All outputs are registered. Reset values: st=0, num=0, temp=0, done=0, state=IDLE.
- rst asserted mid-session clears everything asynchronously. The first edge after release is IDLE behaviour.
- start_btn sampled at edge E: st=1 after E.
- num=1 after E + STAGE_SEC*CLK_HZ RUN edges. HOLD and PAUSE cycles do not count.
- DONE is entered after (NUM_STAGES-1)*STAGE_SEC*CLK_HZ RUN edges. num and done update on the same edge.
- temp follows temp_in with 1-cycle latency.
- The RUN->HOLD transition is taken on the same edge where temp goes 1, so no count occurs on that edge.
- Resuming from HOLD or PAUSE continues from the exact frozen tick_cnt and sec_cnt; no partial-second loss.
- The counting edge on which num reaches NUM_STAGES-1 is final: no further increments, no wrap to 0.

## Test plan
Scenarios 1-4 use CLK_HZ=4, STAGE_SEC=2, NUM_STAGES=12, T_LOW=37, T_HIGH=39.
- Reset/idle: rst pulse, temp_in=20, pause pulses -> st=0, num=0, temp=0, done=0 throughout.
- Nominal run: temp_in=38, start pulse -> st=1 next edge; num increments every 8 edges; num=11 and done=1 after 88 RUN edges; num then holds 11.
- Temperature hold: temp_in=38, start; after 5 RUN edges set temp_in=40 for 20 edges, then 38 -> temp=1 during the excursion; num=1 appears exactly 3 RUN edges after the return (total RUN edges = 8).
- Pause and simultaneous events:
  - Pause for 10 edges mid-stage -> num frozen, same 8-RUN-edge accounting.
  - Pause pulse together with oob -> PAUSE.
  - Start and pause together in IDLE -> RUN.
- Boundaries: temp_in=37 and 39 -> in band, temp=0; 36 and 40 -> temp=1.
- Restart and reset: start pulse in DONE -> num=0, done=0, counting restarts; rst asserted at num=5 -> all outputs 0 immediately.
